ps2_scancode_decoder: RTL and testbench

Downstream stage of the PS/2 keyboard receiver. Consumes validated 8-bit Set-2 scancodes, tracks make/break/extended prefixes and modifier state, translates make codes to 8-bit ASCII, and buffers the characters in a small FIFO. A CPU-side reader pops the characters through a ready/pop handshake. Everything runs in the `system_clk` domain; the receiver's byte output is already synchronised to `system_clk` before it reaches this block.

---
 rtl/kbd_pkg.sv | 86 ++++++++
 rtl/kbd_char_fifo.sv | 56 +++++
 rtl/ps2_scancode_decoder.sv | 127 ++++++++++++
 tb/tb_ps2_scancode_decoder.sv | 269 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/kbd_pkg.sv
// Shared scancode constants, prefix FSM state type and Set-2 to ASCII translation
// for the PS/2 scancode decoder.
package kbd_pkg;

  localparam logic [7:0] SC_BREAK  = 8'hF0;
  localparam logic [7:0] SC_EXT    = 8'hE0;
  localparam logic [7:0] SC_LSHIFT = 8'h12;
  localparam logic [7:0] SC_RSHIFT = 8'h59;
  localparam logic [7:0] SC_CAPS   = 8'h58;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_BRK     = 2'd1,
    ST_EXT     = 2'd2,
    ST_EXT_BRK = 2'd3
  } kbd_state_t;

  function automatic logic sc_is_letter(input logic [7:0] code);
    logic r;
    case (code)
      8'h1C, 8'h32, 8'h21, 8'h23, 8'h24, 8'h2B, 8'h34, 8'h33, 8'h43,
      8'h3B, 8'h42, 8'h4B, 8'h3A, 8'h31, 8'h44, 8'h4D, 8'h15, 8'h2D,
      8'h1B, 8'h2C, 8'h3C, 8'h2A, 8'h1D, 8'h22, 8'h35, 8'h1A: r = 1'b1;
      default: r = 1'b0;
    endcase
    return r;
  endfunction

  // Returns {valid, ascii}; 'upper' selects capitals for letters and the
  // shifted symbol row for digits.
  function automatic logic [8:0] sc_to_ascii(input logic [7:0] code, input logic upper);
    logic [7:0] c;
    logic       v;
    c = 8'h00;
    v = 1'b1;
    case (code)
      8'h1C: c = 8'h61;
      8'h32: c = 8'h62;
      8'h21: c = 8'h63;
      8'h23: c = 8'h64;
      8'h24: c = 8'h65;
      8'h2B: c = 8'h66;
      8'h34: c = 8'h67;
      8'h33: c = 8'h68;
      8'h43: c = 8'h69;
      8'h3B: c = 8'h6A;
      8'h42: c = 8'h6B;
      8'h4B: c = 8'h6C;
      8'h3A: c = 8'h6D;
      8'h31: c = 8'h6E;
      8'h44: c = 8'h6F;
      8'h4D: c = 8'h70;
      8'h15: c = 8'h71;
      8'h2D: c = 8'h72;
      8'h1B: c = 8'h73;
      8'h2C: c = 8'h74;
      8'h3C: c = 8'h75;
      8'h2A: c = 8'h76;
      8'h1D: c = 8'h77;
      8'h22: c = 8'h78;
      8'h35: c = 8'h79;
      8'h1A: c = 8'h7A;
      8'h45: c = upper ? 8'h29 : 8'h30;
      8'h16: c = upper ? 8'h21 : 8'h31;
      8'h1E: c = upper ? 8'h40 : 8'h32;
      8'h26: c = upper ? 8'h23 : 8'h33;
      8'h25: c = upper ? 8'h24 : 8'h34;
      8'h2E: c = upper ? 8'h25 : 8'h35;
      8'h36: c = upper ? 8'h5E : 8'h36;
      8'h3D: c = upper ? 8'h26 : 8'h37;
      8'h3E: c = upper ? 8'h2A : 8'h38;
      8'h46: c = upper ? 8'h28 : 8'h39;
      8'h29: c = 8'h20;
      8'h5A: c = 8'h0D;
      8'h66: c = 8'h08;
      8'h0D: c = 8'h09;
      8'h76: c = 8'h1B;
      default: v = 1'b0;
    endcase
    if (upper && sc_is_letter(code)) begin
      c = c ^ 8'h20;
    end
    return {v, c};
  endfunction

endpackage

// File: rtl/kbd_char_fifo.sv
// Character FIFO: count-based full/empty, a push into a full FIFO is accepted
// only when a pop happens in the same cycle.
module kbd_char_fifo #(
  parameter int DEPTH = 8,
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout,
  output logic [6:0]       count,
  output logic             full,
  output logic             empty
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wr_ptr;
  logic [AW-1:0]    r_rd_ptr;
  logic [6:0]       r_count;
  logic             w_pop;
  logic             w_push;

  assign empty  = (r_count == 7'd0);
  assign full   = (r_count == 7'(DEPTH));
  assign w_pop  = pop && !empty;
  assign w_push = push && (!full || w_pop);
  assign count  = r_count;
  assign dout   = empty ? '0 : r_mem[r_rd_ptr];

  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem[r_wr_ptr] <= din;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= 7'd0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 7'd1;
        2'b01:   r_count <= r_count - 7'd1;
        default: r_count <= r_count;
      endcase
    end
  end

endmodule

// File: rtl/ps2_scancode_decoder.sv
// Set-2 scancode decoder: prefix FSM, shift (and optional caps lock, macro
// KBD_CAPS_LOCK_EN) tracking, ASCII translation and character FIFO.
module ps2_scancode_decoder
  import kbd_pkg::*;
#(
  parameter int FIFO_DEPTH = 8
) (
  input  logic       system_clk,
  input  logic       reset,
  input  logic       scan_valid,
  input  logic [7:0] scan_code,
  input  logic       char_pop,
  output logic       char_ready,
  output logic [7:0] char_out,
  output logic [6:0] char_count,
  output logic       overflow,
  output logic       shift_active
);

  kbd_state_t r_state;
  kbd_state_t w_state_next;
  logic       w_is_make;
  logic       w_is_break;
  logic       r_lshift;
  logic       r_rshift;
  logic       w_caps;
  logic       w_upper;
  logic [8:0] w_xlat;
  logic [7:0] r_char;
  logic       r_push;
  logic       r_overflow;
  logic       w_full;
  logic       w_empty;
  logic       w_pop;

  always_ff @(posedge system_clk or posedge reset) begin
    if (reset) r_state <= ST_IDLE;
    else       r_state <= w_state_next;
  end

  always_comb begin
    w_state_next = r_state;
    w_is_make    = 1'b0;
    w_is_break   = 1'b0;
    if (scan_valid) begin
      case (r_state)
        ST_IDLE: begin
          if (scan_code == SC_BREAK)    w_state_next = ST_BRK;
          else if (scan_code == SC_EXT) w_state_next = ST_EXT;
          else                          w_is_make    = 1'b1;
        end
        ST_BRK: begin
          w_is_break   = 1'b1;
          w_state_next = ST_IDLE;
        end
        // Extended keys are not translated; only the F0 of an extended break matters
        ST_EXT:     w_state_next = (scan_code == SC_BREAK) ? ST_EXT_BRK : ST_IDLE;
        ST_EXT_BRK: w_state_next = ST_IDLE;
        default:    w_state_next = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge system_clk or posedge reset) begin
    if (reset) begin
      r_lshift <= 1'b0;
      r_rshift <= 1'b0;
    end else begin
      if (w_is_make && scan_code == SC_LSHIFT)  r_lshift <= 1'b1;
      if (w_is_break && scan_code == SC_LSHIFT) r_lshift <= 1'b0;
      if (w_is_make && scan_code == SC_RSHIFT)  r_rshift <= 1'b1;
      if (w_is_break && scan_code == SC_RSHIFT) r_rshift <= 1'b0;
    end
  end

`ifdef KBD_CAPS_LOCK_EN
  logic r_caps;
  always_ff @(posedge system_clk or posedge reset) begin
    if (reset)                                     r_caps <= 1'b0;
    else if (w_is_make && scan_code == SC_CAPS)    r_caps <= ~r_caps;
  end
  assign w_caps = r_caps;
`else
  assign w_caps = 1'b0;
`endif

  assign shift_active = r_lshift | r_rshift;
  // Caps lock only flips letter case; digits follow shift alone
  assign w_upper = sc_is_letter(scan_code) ? (shift_active ^ w_caps) : shift_active;
  assign w_xlat  = sc_to_ascii(scan_code, w_upper);

  always_ff @(posedge system_clk or posedge reset) begin
    if (reset) begin
      r_char <= 8'h00;
      r_push <= 1'b0;
    end else begin
      r_push <= w_is_make && w_xlat[8];
      if (w_is_make) r_char <= w_xlat[7:0];
    end
  end

  assign w_pop = char_pop && !w_empty;

  always_ff @(posedge system_clk or posedge reset) begin
    if (reset)                            r_overflow <= 1'b0;
    else if (r_push && w_full && !w_pop)  r_overflow <= 1'b1;
  end

  assign overflow   = r_overflow;
  assign char_ready = !w_empty;

  kbd_char_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (8)
  ) u_fifo (
    .clk   (system_clk),
    .rst   (reset),
    .push  (r_push),
    .pop   (char_pop),
    .din   (r_char),
    .dout  (char_out),
    .count (char_count),
    .full  (w_full),
    .empty (w_empty)
  );

endmodule

// File: tb/tb_ps2_scancode_decoder.sv
// Randomised and directed bench for ps2_scancode_decoder against a queue-based
// key-table model; honours KBD_CAPS_LOCK_EN like the design.
module tb_ps2_scancode_decoder;

  localparam int DEPTH = 4;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       scan_valid = 1'b0;
  logic [7:0] scan_code = 8'h00;
  logic       char_pop = 1'b0;
  logic       char_ready;
  logic [7:0] char_out;
  logic [6:0] char_count;
  logic       overflow;
  logic       shift_active;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  ps2_scancode_decoder #(.FIFO_DEPTH(DEPTH)) dut (
    .system_clk   (clk),
    .reset        (reset),
    .scan_valid   (scan_valid),
    .scan_code    (scan_code),
    .char_pop     (char_pop),
    .char_ready   (char_ready),
    .char_out     (char_out),
    .char_count   (char_count),
    .overflow     (overflow),
    .shift_active (shift_active)
  );

  // Key tables: letter i -> 'a'+i, digit i -> '0'+i or shifted symbol i
  logic [7:0] letter_codes [26] = '{8'h1C, 8'h32, 8'h21, 8'h23, 8'h24, 8'h2B, 8'h34, 8'h33, 8'h43,
                                    8'h3B, 8'h42, 8'h4B, 8'h3A, 8'h31, 8'h44, 8'h4D, 8'h15, 8'h2D,
                                    8'h1B, 8'h2C, 8'h3C, 8'h2A, 8'h1D, 8'h22, 8'h35, 8'h1A};
  logic [7:0] digit_codes [10] = '{8'h45, 8'h16, 8'h1E, 8'h26, 8'h25, 8'h2E, 8'h36, 8'h3D, 8'h3E, 8'h46};
  logic [7:0] digit_syms  [10] = '{8'h29, 8'h21, 8'h40, 8'h23, 8'h24, 8'h25, 8'h5E, 8'h26, 8'h2A, 8'h28};
  logic [7:0] spec_codes  [5]  = '{8'h29, 8'h5A, 8'h66, 8'h0D, 8'h76};
  logic [7:0] spec_chars  [5]  = '{8'h20, 8'h0D, 8'h08, 8'h09, 8'h1B};

  // Model state
  logic [7:0] m_q [$];
  logic       m_ovf, m_pend, m_after_f0, m_after_e0, m_lsh, m_rsh, m_caps;
  logic [7:0] m_pend_ch;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_q.delete();
    m_ovf = 0; m_pend = 0; m_pend_ch = 8'h00;
    m_after_f0 = 0; m_after_e0 = 0; m_lsh = 0; m_rsh = 0; m_caps = 0;
  endtask

  task automatic lookup(input logic [7:0] code, output logic v, output logic [7:0] ch);
    logic sh;
    sh = m_lsh | m_rsh;
    v = 0; ch = 8'h00;
    for (int i = 0; i < 26; i++)
      if (letter_codes[i] == code) begin
        v = 1;
        ch = ((sh ^ m_caps) ? 8'h41 : 8'h61) + 8'(i);
      end
    for (int i = 0; i < 10; i++)
      if (digit_codes[i] == code) begin
        v = 1;
        ch = sh ? digit_syms[i] : 8'h30 + 8'(i);
      end
    for (int i = 0; i < 5; i++)
      if (spec_codes[i] == code) begin
        v = 1;
        ch = spec_chars[i];
      end
  endtask

  task automatic model_edge(input logic sv, input logic [7:0] code, input logic pop);
    bit full, pop_eff;
    logic v;
    logic [7:0] ch;
    full = (m_q.size() == DEPTH);
    pop_eff = pop && (m_q.size() > 0);
    if (pop_eff) void'(m_q.pop_front());
    if (m_pend) begin
      if (!full || pop_eff) m_q.push_back(m_pend_ch);
      else m_ovf = 1;
    end
    m_pend = 0;
    if (sv) begin
      if (m_after_e0 && m_after_f0) begin
        m_after_e0 = 0; m_after_f0 = 0;
      end else if (m_after_e0) begin
        if (code == 8'hF0) m_after_f0 = 1;
        else m_after_e0 = 0;
      end else if (m_after_f0) begin
        if (code == 8'h12) m_lsh = 0;
        if (code == 8'h59) m_rsh = 0;
        m_after_f0 = 0;
      end else if (code == 8'hF0) begin
        m_after_f0 = 1;
      end else if (code == 8'hE0) begin
        m_after_e0 = 1;
      end else begin
        lookup(code, v, ch);
        if (v) begin
          m_pend = 1; m_pend_ch = ch;
        end
        if (code == 8'h12) m_lsh = 1;
        if (code == 8'h59) m_rsh = 1;
`ifdef KBD_CAPS_LOCK_EN
        if (code == 8'h58) m_caps = ~m_caps;
`endif
      end
    end
  endtask

  task automatic check_outputs();
    check("char_ready", char_ready, m_q.size() != 0);
    check("char_count", char_count, m_q.size());
    check("char_out", char_out, (m_q.size() != 0) ? m_q[0] : 8'h00);
    check("overflow", overflow, m_ovf);
    check("shift_active", shift_active, m_lsh | m_rsh);
  endtask

  // Called at a negedge: drive, step model over the next posedge, check at next negedge
  task automatic cycle(input logic sv, input logic [7:0] code, input logic pop);
    if (pop && m_q.size() != 0) $display("[TB] pop 0x%02h", m_q[0]);
    scan_valid = sv; scan_code = code; char_pop = pop;
    model_edge(sv, code, pop);
    @(posedge clk);
    @(negedge clk);
    scan_valid = 0; char_pop = 0;
    check_outputs();
  endtask

  task automatic send(input logic [7:0] code);
    cycle(1, code, 0);
    cycle(0, 8'h00, 0);
  endtask

  task automatic do_reset();
    reset = 1; scan_valid = 0; char_pop = 0;
    model_reset();
    #1;
    check_outputs();
    @(negedge clk);
    reset = 0;
  endtask

  task automatic drain();
    for (int i = 0; i < DEPTH + 1; i++) cycle(0, 8'h00, 1);
  endtask

  function automatic logic [7:0] pick();
    int r;
    r = $urandom_range(0, 9);
    case (r)
      0, 1, 2, 3: return letter_codes[$urandom_range(0, 25)];
      4, 5:       return digit_codes[$urandom_range(0, 9)];
      6: begin
        int k;
        k = $urandom_range(0, 2);
        return (k == 0) ? 8'h12 : (k == 1) ? 8'h59 : 8'h58;
      end
      7:       return 8'hF0;
      8:       return 8'hE0;
      default: return 8'($urandom_range(0, 255));
    endcase
  endfunction

  initial begin
    model_reset();
    @(negedge clk);
    do_reset();
    check("rst_count_lit", char_count, 0);
    check("rst_out_lit", char_out, 8'h00);

    // make/break of 'a' yields exactly one character, written one edge later
    cycle(1, 8'h1C, 0);
    check("a_count_edge_n", char_count, 0);
    cycle(0, 8'h00, 0);
    check("a_count_edge_n1", char_count, 1);
    send(8'hF0); send(8'h1C);
    check("a_only_one", char_count, 1);
    check("a_char", char_out, 8'h61);
    drain();

    // shift held then released
    send(8'h12);
    check("shift_on", shift_active, 1);
    send(8'h1C); send(8'hF0); send(8'h12);
    check("shift_off", shift_active, 0);
    send(8'h1C);
    check("A_first", char_out, 8'h41);
    cycle(0, 8'h00, 1);
    check("a_second", char_out, 8'h61);
    drain();

    // extended up-arrow make/break is discarded
    send(8'hE0); send(8'h75); send(8'hE0); send(8'hF0); send(8'h75);
    check("ext_none", char_count, 0);
    send(8'h16);
    check("ext_then_1", char_out, 8'h31);
    drain();

    // overflow with five 'b' makes, then drain
    for (int i = 0; i < 5; i++) send(8'h32);
    check("ovf_count", char_count, DEPTH);
    check("ovf_flag", overflow, 1);
    for (int i = 0; i < DEPTH; i++) begin
      check("ovf_pop_char", char_out, 8'h62);
      cycle(0, 8'h00, 1);
    end
    cycle(0, 8'h00, 1);
    check("empty_pop_ignored", char_count, 0);
    check("ovf_sticky", overflow, 1);

    // full FIFO: push coincides with pop
    do_reset();
    send(8'h1C); send(8'h32); send(8'h21); send(8'h23);
    cycle(1, 8'h24, 0);
    cycle(0, 8'h00, 1);
    check("full_pp_count", char_count, DEPTH);
    check("full_pp_ovf", overflow, 0);
    check("full_pp_head", char_out, 8'h62);
    drain();

`ifdef KBD_CAPS_LOCK_EN
    send(8'h58); send(8'hF0); send(8'h58); send(8'h1C);
    check("caps_A", char_out, 8'h41);
    send(8'h12); send(8'h1C);
    cycle(0, 8'h00, 1);
    check("caps_shift_a", char_out, 8'h61);
    send(8'hF0); send(8'h12); send(8'h58);
    drain();
`else
    send(8'h58); send(8'h1C);
    check("nocaps_count", char_count, 1);
    check("nocaps_a", char_out, 8'h61);
    drain();
`endif

    // reset between F0 and 1C: prefix and shift forgotten
    send(8'h12); send(8'hF0);
    do_reset();
    send(8'h1C);
    check("rst_mid_a", char_out, 8'h61);
    drain();

    // randomised traffic
    for (int n = 0; n < 1500; n++) begin
      cycle(1, pick(), $urandom_range(0, 3) == 0);
      repeat ($urandom_range(1, 3)) cycle(0, 8'h00, $urandom_range(0, 3) == 0);
      if ($urandom_range(0, 299) == 0) do_reset();
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
